// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: FSM state encodings
// and the default HALT encoding.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO holding {pc, instruction} pairs between the memory
// response path and the decode consumer.
module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues word reads to instruction
// memory, buffers responses and handles redirects and HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   PC_W      = 16,
    parameter int                   INSTR_W   = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   HALT_WORD = INSTR_W'(DEFAULT_HALT_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]    imem_rdata,
    input  logic                  imem_valid,
    output logic                  instr_valid,
    output logic [INSTR_W-1:0]    instr,
    output logic [PC_W-1:0]       instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = PC_W + INSTR_W;

    state_t              state;
    state_t              next_state;
    logic [PC_W-1:0]     fetch_pc;
    logic [PC_W-1:0]     inflight_pc;
    logic                epoch;
    logic                inflight;
    logic                inflight_epoch;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      occupancy;
    logic                room;
    logic                deq;
    logic                enq;
    logic [ENT_W-1:0]    head;

    // A response is kept only if it belongs to the current epoch and no
    // redirect is flushing the queue on this same edge.
    assign enq       = imem_valid && inflight && (inflight_epoch == epoch) && !redirect_valid;
    assign deq       = instr_valid && instr_ready;
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign room      = occupancy < ((CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(deq));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_BOOT:  next_state = S_RUN;
            S_RUN:   if (enq && (imem_rdata == HALT_WORD)) next_state = S_HALT;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_BOOT;
        endcase
        if (redirect_valid) begin
            next_state = S_RUN;
        end
    end

    always_comb begin
        imem_req = (state == S_RUN) && !redirect_valid && room;
        halted   = (state == S_HALT);
    end

    // Memory answers exactly one cycle after a request, so the in-flight tag
    // is simply last cycle's request together with its address and epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_epoch <= epoch;
                inflight_pc    <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    assign imem_addr = fetch_pc;

    fetch_queue #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_valid),
        .wr      (enq),
        .wr_data ({inflight_pc, imem_rdata}),
        .rd      (deq),
        .rd_data (head),
        .count   (count)
    );

    // Head fields read as zero while the queue is empty.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head[INSTR_W-1:0] : '0;
    assign instr_pc    = instr_valid ? head[ENT_W-1:INSTR_W] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a random
// ready/redirect phase, checked against an instruction-stream model.
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req, a_ivalid, a_halted, a_ready, a_rv;
    logic [15:0] a_addr, a_ipc, a_rpc;
    logic [31:0] a_rdata, a_instr;
    logic        a_mvalid = 1'b0;

    logic        b_req, b_ivalid, b_halted, b_ready, b_rv;
    logic [15:0] b_addr, b_ipc, b_rpc;
    logic [31:0] b_rdata, b_instr;
    logic        b_mvalid = 1'b0;

    logic        halt_en;
    logic [15:0] halt_addr;
    int          a_reqs = 0;

    int          compared = 0;
    int          mismatched = 0;

    logic [15:0] exp_pc, hp, b_exp;
    bit          halt_seen, extra_used, want_valid;
    int          quiet, consumed, idle_run, max_idle, b_seen;

    fetch_unit dut_a (
        .clk(clk), .rst(rst),
        .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata), .imem_valid(a_mvalid),
        .instr_valid(a_ivalid), .instr(a_instr), .instr_pc(a_ipc), .instr_ready(a_ready),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .halted(a_halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata), .imem_valid(b_mvalid),
        .instr_valid(b_ivalid), .instr(b_instr), .instr_pc(b_ipc), .instr_ready(b_ready),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .halted(b_halted)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] addr, input bit use_halt);
        if (use_halt && halt_en && addr == halt_addr) return HALT;
        return 32'(addr) + 32'd100;
    endfunction

    // Instruction memories: data one cycle after each request.
    always @(posedge clk) begin
        a_mvalid <= a_req;
        a_rdata  <= mem_word(a_addr, 1'b1);
        b_mvalid <= b_req;
        b_rdata  <= mem_word(b_addr, 1'b0);
        if (a_req) a_reqs <= a_reqs + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        exp_pc     = 16'h0000;
        halt_seen  = 1'b0;
        extra_used = 1'b0;
        quiet      = 3;
        want_valid = 1'b0;
        idle_run   = 0;
        b_exp      = 16'hFFFE;
        b_seen     = 0;
    endtask

    // One cycle: drive inputs at the falling edge, check the stream, advance.
    task automatic applyStimulus(input bit ready, input bit rv, input logic [15:0] rpc);
        a_ready = ready;
        a_rv    = rv;
        a_rpc   = rpc;
        #1;
        if (quiet > 0) begin
            checkOutput("bubble_valid", 64'(a_ivalid), 64'd0);
            quiet--;
            if (quiet == 0) want_valid = 1'b1;
        end else if (want_valid) begin
            checkOutput("first_valid", 64'(a_ivalid), 64'd1);
            want_valid = 1'b0;
        end
        if (halt_seen) begin
            checkOutput("halted_flag", 64'(a_halted), 64'd1);
            checkOutput("halt_no_req", 64'(a_req), 64'd0);
        end
        if (a_ivalid) idle_run = 0;
        else if (!halt_seen) begin
            idle_run++;
            if (idle_run > max_idle) max_idle = idle_run;
        end
        if (a_ivalid && ready) begin
            consumed++;
            if (halt_seen) begin
                if (!extra_used && a_ipc == hp + 16'd1) begin
                    extra_used = 1'b1;
                    checkOutput("extra_instr", 64'(a_instr), 64'(mem_word(a_ipc, 1'b1)));
                end else begin
                    checkOutput("post_halt_delivery", 64'(a_ivalid), 64'd0);
                end
            end else begin
                checkOutput("instr_pc", 64'(a_ipc), 64'(exp_pc));
                checkOutput("instr", 64'(a_instr), 64'(mem_word(exp_pc, 1'b1)));
                if (mem_word(exp_pc, 1'b1) == HALT) begin
                    halt_seen = 1'b1;
                    hp        = exp_pc;
                end
                exp_pc++;
            end
        end
        if (b_ivalid && b_seen < 4) begin
            checkOutput("b_pc", 64'(b_ipc), 64'(b_exp));
            checkOutput("b_instr", 64'(b_instr), 64'(mem_word(b_exp, 1'b0)));
            b_exp++;
            b_seen++;
        end
        if (rv) begin
            exp_pc     = rpc;
            halt_seen  = 1'b0;
            extra_used = 1'b0;
            quiet      = 2;
            want_valid = 1'b0;
            idle_run   = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int base, c0;
        bit r, rv;
        logic [15:0] t;
        rst = 1'b1;
        a_ready = 1'b0; a_rv = 1'b0; a_rpc = '0;
        b_ready = 1'b1; b_rv = 1'b0; b_rpc = '0;
        halt_en = 1'b0; halt_addr = '0;
        consumed = 0; max_idle = 0;
        resetModel();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_req", 64'(a_req), 64'd0);
        checkOutput("rst_addr", 64'(a_addr), 64'h0);
        checkOutput("rst_valid", 64'(a_ivalid), 64'd0);
        checkOutput("rst_instr", 64'(a_instr), 64'd0);
        checkOutput("rst_ipc", 64'(a_ipc), 64'd0);
        checkOutput("rst_halted", 64'(a_halted), 64'd0);
        checkOutput("rst_b_addr", 64'(b_addr), 64'hFFFE);
        base = a_reqs;
        @(negedge clk);
        rst = 1'b0;
        resetModel();

        // Stall from reset: queue fills to DEPTH, head stays pc 0
        applyStimulus(1'b0, 1'b0, 16'h0);
        #1;
        checkOutput("first_req", 64'(a_req), 64'd1);
        checkOutput("first_addr", 64'(a_addr), 64'h0);
        repeat (11) applyStimulus(1'b0, 1'b0, 16'h0);
        #1;
        checkOutput("full_no_req", 64'(a_req), 64'd0);
        checkOutput("full_req_count", 64'(a_reqs - base), 64'd4);
        checkOutput("stall_head_pc", 64'(a_ipc), 64'd0);
        checkOutput("stall_head_instr", 64'(a_instr), 64'd100);

        // Drain and steady streaming
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0);
        c0 = consumed;
        repeat (10) applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("throughput", 64'(consumed - c0), 64'd10);

        // Redirect with a full-ish queue and a response in flight
        applyStimulus(1'b1, 1'b1, 16'h0040);
        repeat (12) applyStimulus(1'b1, 1'b0, 16'h0);

        // HALT at address 5
        halt_addr = 16'h0005;
        halt_en   = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0000);
        c0 = consumed;
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("halted_after_halt", 64'(a_halted), 64'd1);
        checkOutput("halt_delivery_count", 64'((consumed - c0 == 6) || (consumed - c0 == 7)), 64'd1);
        applyStimulus(1'b1, 1'b1, 16'h0010);
        #1;
        checkOutput("unhalted", 64'(a_halted), 64'd0);
        repeat (10) applyStimulus(1'b1, 1'b0, 16'h0);

        // Asynchronous reset while a response is pending
        halt_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_req", 64'(a_req), 64'd0);
        checkOutput("arst_addr", 64'(a_addr), 64'h0);
        checkOutput("arst_valid", 64'(a_ivalid), 64'd0);
        checkOutput("arst_instr", 64'(a_instr), 64'd0);
        checkOutput("arst_ipc", 64'(a_ipc), 64'd0);
        checkOutput("arst_b_addr", 64'(b_addr), 64'hFFFE);
        #1 rst = 1'b0;
        resetModel();
        @(negedge clk);
        repeat (15) applyStimulus(1'b1, 1'b0, 16'h0);

        // Random ready/redirect traffic around a HALT at 0x0030
        halt_addr = 16'h0030;
        halt_en   = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 99) < 75);
            rv = ($urandom_range(0, 99) < 4) || (halt_seen && $urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       t = 16'h0028 + 16'($urandom_range(0, 8));
                1:       t = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: t = 16'($urandom);
            endcase
            applyStimulus(r, rv, t);
        end
        checkOutput("max_idle_ok", 64'(max_idle <= 3), 64'd1);
        checkOutput("progress", 64'(consumed > 500), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
